gate_bist_ctrl: RTL

GATE_BIST_CTRL -- requirements
Module: gate_bist_ctrl

---
 rtl/gate_bist_ctrl_pkg.sv | 19 +
 rtl/gate_bist_ctrl_settle_timer.sv | 23 ++
 rtl/gate_bist_ctrl.sv | 87 ++++++++
 3 files changed

// File: rtl/gate_bist_ctrl_pkg.sv
// Shared encodings for the gate BIST controller: FSM states and
// reference truth tables (bit i = y for {a,b}=i).
package gate_bist_ctrl_pkg;
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } bist_state_e;

  localparam logic [3:0] TT_AND  = 4'b1000;
  localparam logic [3:0] TT_OR   = 4'b1110;
  localparam logic [3:0] TT_NAND = 4'b0111;
  localparam logic [3:0] TT_NOR  = 4'b0001;
  localparam logic [3:0] TT_XOR  = 4'b0110;
  localparam logic [3:0] TT_XNOR = 4'b1001;

  localparam int CNT_W = 8;
endpackage

// File: rtl/gate_bist_ctrl_settle_timer.sv
// Settle timer: load restarts the count at 0, run advances it; expired is
// raised on the last of SETTLE cycles so the FSM leaves WAIT on that edge.
module settle_timer
  import gate_bist_ctrl_pkg::*;
#(
  parameter int SETTLE = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic run,
  output logic expired
);
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       cnt <= '0;
    else if (load) cnt <= '0;
    else if (run)  cnt <= cnt + 1'b1;
  end

  assign expired = (cnt == CNT_W'(SETTLE - 1));
endmodule

// File: rtl/gate_bist_ctrl.sv
// Truth-table BIST controller for an external 2-input gate: walks {a,b}
// through 00..11, samples y after a settle window and reports pass/fail_vec.
module gate_bist_ctrl
  import gate_bist_ctrl_pkg::*;
#(
  parameter logic [3:0] EXPECT = TT_XNOR,
  parameter int         SETTLE = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       y,
  output logic       a,
  output logic       b,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] fail_vec
);
  bist_state_e state;
  logic [1:0]  idx;
  logic        expired;
  logic        load;
  logic        run;
  logic        mis;

  // Counter restarts on sweep accept and on every vector advance out of SAMPLE.
  assign load = ((state == IDLE) && start) || (state == SAMPLE);
  assign run  = (state == WAIT);
  assign mis  = (y != EXPECT[idx]);

  settle_timer #(.SETTLE(SETTLE)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .load    (load),
    .run     (run),
    .expired (expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      idx      <= 2'd0;
      a        <= 1'b0;
      b        <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      pass     <= 1'b0;
      fail_vec <= 4'b0000;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            state    <= WAIT;
            idx      <= 2'd0;
            a        <= 1'b0;
            b        <= 1'b0;
            busy     <= 1'b1;
            pass     <= 1'b0;
            fail_vec <= 4'b0000;
          end
        end
        WAIT: if (expired) state <= SAMPLE;
        SAMPLE: begin
          if (mis) fail_vec[idx] <= 1'b1;
          if (idx != 2'd3) begin
            idx   <= idx + 2'd1;
            {a,b} <= idx + 2'd1;
            state <= WAIT;
          end else begin
            // Fold in this last sample since fail_vec updates on the same edge.
            pass  <= (fail_vec == 4'b0000) && !mis;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
